// File: rtl/mmu_pkg.sv
// Shared encodings for the MMU page pool: response fail reasons and alloc FSM states.
package mmu_pkg;

    localparam logic [1:0] FR_OK       = 2'd0;
    localparam logic [1:0] FR_NO_SPACE = 2'd1;
    localparam logic [1:0] FR_BAD_SIZE = 2'd2;
    localparam logic [1:0] FR_BAD_PAGE = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_STREAM,
        ST_FAILRSP
    } alloc_state_t;

endpackage

// File: rtl/mmu_page_freelist.sv
// Circular free list of page indices. Pointers wrap naturally at NUM_PAGES
// (power of two). Occupancy is tracked by the owner, so no full/empty flags.
module mmu_page_freelist #(
    parameter int NUM_PAGES  = 4096,
    parameter int PAGE_IDX_W = $clog2(NUM_PAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_we,
    input  logic [PAGE_IDX_W-1:0] init_addr,
    input  logic [PAGE_IDX_W-1:0] init_data,
    input  logic                  push,
    input  logic [PAGE_IDX_W-1:0] push_data,
    input  logic                  pop,
    output logic [PAGE_IDX_W-1:0] head
);

    logic [PAGE_IDX_W-1:0] mem [NUM_PAGES];
    logic [PAGE_IDX_W-1:0] rd_ptr;
    logic [PAGE_IDX_W-1:0] wr_ptr;

    // Storage: init sweep and runtime pushes never overlap in time
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= init_data;
        else if (push)
            mem[wr_ptr] <= push_data;
    end

    // Wrapping read/write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PAGE_IDX_W'(1);
            if (push) wr_ptr <= wr_ptr + PAGE_IDX_W'(1);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mmu_page_pool.sv
// Parametrised page allocator: circular free list + allocated bitmap,
// self-initialising, multi-page alloc stream and checked single-page free.
module mmu_page_pool
    import mmu_pkg::*;
#(
    parameter int NUM_PAGES  = 4096,
    parameter int PAGE_IDX_W = $clog2(NUM_PAGES),
    parameter int REQ_ID_W   = 8,
    parameter int MAX_ALLOC  = 16,
    parameter int CNT_W      = $clog2(MAX_ALLOC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req_valid,
    output logic                  alloc_req_ready,
    input  logic [REQ_ID_W-1:0]   alloc_req_id,
    input  logic [CNT_W-1:0]      alloc_req_count,
    output logic                  alloc_rsp_valid,
    input  logic                  alloc_rsp_ready,
    output logic [REQ_ID_W-1:0]   alloc_rsp_id,
    output logic [PAGE_IDX_W-1:0] alloc_rsp_page,
    output logic                  alloc_rsp_last,
    output logic                  alloc_rsp_fail,
    output logic [1:0]            alloc_rsp_fail_reason,
    input  logic                  free_req_valid,
    output logic                  free_req_ready,
    input  logic [REQ_ID_W-1:0]   free_req_id,
    input  logic [PAGE_IDX_W:0]   free_req_page,
    output logic                  free_rsp_valid,
    input  logic                  free_rsp_ready,
    output logic [REQ_ID_W-1:0]   free_rsp_id,
    output logic                  free_rsp_fail,
    output logic [1:0]            free_rsp_fail_reason,
    output logic [PAGE_IDX_W:0]   free_page_count,
    output logic                  init_done
);

    localparam int FPC_W = PAGE_IDX_W + 1;

    alloc_state_t          state;
    logic [CNT_W-1:0]      rem;
    logic [NUM_PAGES-1:0]  bitmap;
    logic [FPC_W-1:0]      init_cnt;
    logic [PAGE_IDX_W-1:0] head;
    logic [PAGE_IDX_W-1:0] free_idx;

    logic init_we, init_last;
    logic alloc_acc, beat_take, page_pop, size_bad, space_bad, alloc_ok;
    logic free_acc, free_bad, free_ok;

    // init_cnt only ever reaches NUM_PAGES, so its top bit marks the sweep end
    assign init_we   = (state == ST_INIT) && !init_cnt[PAGE_IDX_W];
    assign init_last = (state == ST_INIT) &&  init_cnt[PAGE_IDX_W];

    // A finishing last beat frees the response slot in the same cycle
    assign alloc_req_ready = init_done & (~alloc_rsp_valid | (alloc_rsp_ready & alloc_rsp_last));
    assign free_req_ready  = init_done & ~free_rsp_valid;

    assign alloc_acc = alloc_req_valid & alloc_req_ready;
    assign beat_take = alloc_rsp_valid & alloc_rsp_ready;
    assign page_pop  = beat_take & (state == ST_STREAM);
    assign size_bad  = (alloc_req_count == '0) || (int'(alloc_req_count) > MAX_ALLOC);
    // Sufficiency uses the registered count: a same-cycle free is not visible yet
    assign space_bad = int'(alloc_req_count) > int'(free_page_count);
    assign alloc_ok  = alloc_acc & ~size_bad & ~space_bad;

    assign free_idx = free_req_page[PAGE_IDX_W-1:0];
    assign free_acc = free_req_valid & free_req_ready;
    assign free_bad = free_req_page[PAGE_IDX_W] | ~bitmap[free_idx];
    assign free_ok  = free_acc & ~free_bad;

    // Head is only meaningful while streaming; fail beats carry page 0
    assign alloc_rsp_page = (state == ST_STREAM) ? head : '0;

    mmu_page_freelist #(
        .NUM_PAGES  (NUM_PAGES),
        .PAGE_IDX_W (PAGE_IDX_W)
    ) u_freelist (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_cnt[PAGE_IDX_W-1:0]),
        .init_data (init_cnt[PAGE_IDX_W-1:0]),
        .push      (free_ok),
        .push_data (free_idx),
        .pop       (page_pop),
        .head      (head)
    );

    // Alloc FSM: init sweep, accept, stream pages or a single fail beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ST_INIT;
            init_cnt              <= '0;
            init_done             <= 1'b0;
            rem                   <= '0;
            alloc_rsp_valid       <= 1'b0;
            alloc_rsp_id          <= '0;
            alloc_rsp_last        <= 1'b0;
            alloc_rsp_fail        <= 1'b0;
            alloc_rsp_fail_reason <= FR_OK;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_last) begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + FPC_W'(1);
                    end
                end
                default: begin
                    if (beat_take) begin
                        if (alloc_rsp_last) begin
                            alloc_rsp_valid       <= 1'b0;
                            alloc_rsp_last        <= 1'b0;
                            alloc_rsp_fail        <= 1'b0;
                            alloc_rsp_fail_reason <= FR_OK;
                            state                 <= ST_IDLE;
                        end else begin
                            rem            <= rem - CNT_W'(1);
                            alloc_rsp_last <= (rem == CNT_W'(2));
                        end
                    end
                    // Accept overrides the wind-down of a finishing stream
                    if (alloc_acc) begin
                        alloc_rsp_valid <= 1'b1;
                        alloc_rsp_id    <= alloc_req_id;
                        if (size_bad || space_bad) begin
                            state                 <= ST_FAILRSP;
                            alloc_rsp_fail        <= 1'b1;
                            alloc_rsp_last        <= 1'b1;
                            alloc_rsp_fail_reason <= size_bad ? FR_BAD_SIZE : FR_NO_SPACE;
                        end else begin
                            state                 <= ST_STREAM;
                            alloc_rsp_fail        <= 1'b0;
                            alloc_rsp_last        <= (alloc_req_count == CNT_W'(1));
                            alloc_rsp_fail_reason <= FR_OK;
                            rem                   <= alloc_req_count;
                        end
                    end
                end
            endcase
        end
    end

    // Available count: reserve on alloc accept, return on good free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            free_page_count <= '0;
        else if (init_last)
            free_page_count <= FPC_W'(NUM_PAGES);
        else
            free_page_count <= free_page_count + FPC_W'(free_ok)
                               - (alloc_ok ? FPC_W'(alloc_req_count) : '0);
    end

    // Allocated bitmap: a beat and a free always touch distinct pages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
        end else begin
            if (page_pop) bitmap[head]     <= 1'b1;
            if (free_ok)  bitmap[free_idx] <= 1'b0;
        end
    end

    // Free response register, held until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_rsp_valid       <= 1'b0;
            free_rsp_id          <= '0;
            free_rsp_fail        <= 1'b0;
            free_rsp_fail_reason <= FR_OK;
        end else if (free_acc) begin
            free_rsp_valid       <= 1'b1;
            free_rsp_id          <= free_req_id;
            free_rsp_fail        <= free_bad;
            free_rsp_fail_reason <= free_bad ? FR_BAD_PAGE : FR_OK;
        end else if (free_rsp_valid && free_rsp_ready) begin
            free_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmu_page_pool.sv
// Self-checking bench for mmu_page_pool: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random phase.
module tb_mmu_page_pool;

    localparam int NP = 16;
    localparam int PW = 4;
    localparam int IW = 8;
    localparam int MA = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_req_valid, alloc_req_ready;
    logic [IW-1:0] alloc_req_id;
    logic [CW-1:0] alloc_req_count;
    logic          alloc_rsp_valid, alloc_rsp_ready;
    logic [IW-1:0] alloc_rsp_id;
    logic [PW-1:0] alloc_rsp_page;
    logic          alloc_rsp_last, alloc_rsp_fail;
    logic [1:0]    alloc_rsp_fail_reason;
    logic          free_req_valid, free_req_ready;
    logic [IW-1:0] free_req_id;
    logic [PW:0]   free_req_page;
    logic          free_rsp_valid, free_rsp_ready;
    logic [IW-1:0] free_rsp_id;
    logic          free_rsp_fail;
    logic [1:0]    free_rsp_fail_reason;
    logic [PW:0]   free_page_count;
    logic          init_done;

    mmu_page_pool #(
        .NUM_PAGES(NP), .PAGE_IDX_W(PW), .REQ_ID_W(IW), .MAX_ALLOC(MA), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
        .alloc_req_id(alloc_req_id), .alloc_req_count(alloc_req_count),
        .alloc_rsp_valid(alloc_rsp_valid), .alloc_rsp_ready(alloc_rsp_ready),
        .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page(alloc_rsp_page),
        .alloc_rsp_last(alloc_rsp_last), .alloc_rsp_fail(alloc_rsp_fail),
        .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .free_req_valid(free_req_valid), .free_req_ready(free_req_ready),
        .free_req_id(free_req_id), .free_req_page(free_req_page),
        .free_rsp_valid(free_rsp_valid), .free_rsp_ready(free_rsp_ready),
        .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
        .free_rsp_fail_reason(free_rsp_fail_reason),
        .free_page_count(free_page_count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        nchk++;
        nfail++;
        $display("FAIL %s: bound expired or item missing at %0t", nm, $time);
    endtask

    function automatic int bcode(input int id, input int page, input int last, input int fail, input int rsn);
        return (id << 16) | (page << 8) | (last << 3) | (fail << 2) | rsn;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int id; int page; int last; int fail; int rsn; } beat_t;
    typedef struct { int id; int fail; int rsn; } frsp_t;

    beat_t exp_b[$];
    beat_t glog[$];
    frsp_t exp_f[$];
    frsp_t flog[$];
    int    fq[$];
    bit    mmap [NP];
    int    m_fpc = 0;
    bit    m_init = 1'b0;
    int    pc = 0;

    // Cycles since reset release; the pool must be usable after NP+1 of them
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    // Compare process: check outputs, then apply this cycle's handshakes to the model
    always @(negedge clk) begin
        int    p, n, fpc0;
        beat_t b;
        frsp_t f;
        if (!rst_n) begin
            exp_b.delete(); exp_f.delete(); fq.delete();
            m_fpc = 0; m_init = 1'b0;
            foreach (mmap[i]) mmap[i] = 1'b0;
            chk("rst_alloc_rsp_valid", alloc_rsp_valid, 0);
            chk("rst_free_rsp_valid", free_rsp_valid, 0);
            chk("rst_free_page_count", free_page_count, 0);
            chk("rst_init_done", init_done, 0);
        end else begin
            if (pc >= NP + 1 && !m_init) begin
                m_init = 1'b1;
                m_fpc = NP;
                for (int k = 0; k < NP; k++) fq.push_back(k);
            end
            chk("init_done", init_done, m_init);
            chk("free_page_count", free_page_count, m_fpc);
            chk("alloc_req_ready", alloc_req_ready,
                m_init && (exp_b.size() == 0 || (exp_b.size() == 1 && alloc_rsp_ready)));
            chk("free_req_ready", free_req_ready, m_init && exp_f.size() == 0);
            chk("alloc_rsp_valid", alloc_rsp_valid, exp_b.size() != 0);
            chk("free_rsp_valid", free_rsp_valid, exp_f.size() != 0);
            if (alloc_rsp_valid && exp_b.size() != 0)
                chk("alloc_rsp_beat",
                    bcode(alloc_rsp_id, alloc_rsp_page, alloc_rsp_last, alloc_rsp_fail, alloc_rsp_fail_reason),
                    bcode(exp_b[0].id, exp_b[0].page, exp_b[0].last, exp_b[0].fail, exp_b[0].rsn));
            if (free_rsp_valid && exp_f.size() != 0)
                chk("free_rsp",
                    bcode(free_rsp_id, 0, 0, free_rsp_fail, free_rsp_fail_reason),
                    bcode(exp_f[0].id, 0, 0, exp_f[0].fail, exp_f[0].rsn));

            fpc0 = m_fpc;
            if (free_req_valid && free_req_ready) begin
                p = free_req_page;
                if (p >= NP || !mmap[p]) begin
                    exp_f.push_back('{free_req_id, 1, 3});
                end else begin
                    mmap[p] = 1'b0;
                    fq.push_back(p);
                    m_fpc++;
                    exp_f.push_back('{free_req_id, 0, 0});
                end
            end
            if (alloc_req_valid && alloc_req_ready) begin
                n = alloc_req_count;
                if (n == 0 || n > MA) begin
                    exp_b.push_back('{alloc_req_id, 0, 1, 1, 2});
                end else if (n > fpc0) begin
                    exp_b.push_back('{alloc_req_id, 0, 1, 1, 1});
                end else begin
                    m_fpc -= n;
                    for (int k = 0; k < n; k++)
                        exp_b.push_back('{alloc_req_id, fq.pop_front(), (k == n - 1) ? 1 : 0, 0, 0});
                end
            end
            if (alloc_rsp_valid && alloc_rsp_ready && exp_b.size() != 0) begin
                b = exp_b.pop_front();
                if (b.fail == 0) mmap[b.page] = 1'b1;
                glog.push_back('{alloc_rsp_id, alloc_rsp_page, alloc_rsp_last, alloc_rsp_fail, alloc_rsp_fail_reason});
            end
            if (free_rsp_valid && free_rsp_ready && exp_f.size() != 0) begin
                f = exp_f.pop_front();
                flog.push_back('{free_rsp_id, free_rsp_fail, free_rsp_fail_reason});
            end
        end
    end

    // Response-ready drivers: 0 = held low, 1 = held high, 2 = random
    int amode = 1;
    int fmode = 1;
    always @(posedge clk) begin
        #1;
        alloc_rsp_ready = (amode == 2) ? 1'($urandom_range(0, 1)) : (amode == 1);
        free_rsp_ready  = (fmode == 2) ? 1'($urandom_range(0, 1)) : (fmode == 1);
    end

    // ---------------- drivers ----------------
    task automatic do_alloc(input int id, input int cnt);
        alloc_req_id = IW'(id);
        alloc_req_count = CW'(cnt);
        alloc_req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (alloc_req_ready) begin
                @(posedge clk); #1;
                alloc_req_valid = 1'b0;
                return;
            end
        end
        alloc_req_valid = 1'b0;
        tmo("alloc_accept");
    endtask

    task automatic do_free(input int id, input int page);
        free_req_id = IW'(id);
        free_req_page = (PW + 1)'(page);
        free_req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (free_req_ready) begin
                @(posedge clk); #1;
                free_req_valid = 1'b0;
                return;
            end
        end
        free_req_valid = 1'b0;
        tmo("free_accept");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_b.size() == 0 && exp_f.size() == 0 && !alloc_rsp_valid && !free_rsp_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        tmo("wait_idle");
    endtask

    task automatic chk_beat(input string nm, input int i, input int id, input int page,
                            input int last, input int fail, input int rsn);
        if (i < glog.size())
            chk(nm, bcode(glog[i].id, glog[i].page, glog[i].last, glog[i].fail, glog[i].rsn),
                bcode(id, page, last, fail, rsn));
        else
            tmo(nm);
    endtask

    task automatic chk_frsp(input string nm, input int i, input int id, input int fail, input int rsn);
        if (i < flog.size())
            chk(nm, bcode(flog[i].id, 0, 0, flog[i].fail, flog[i].rsn), bcode(id, 0, 0, fail, rsn));
        else
            tmo(nm);
    endtask

    function automatic int pick_page();
        int cand[$];
        for (int i = 0; i < NP; i++) if (mmap[i]) cand.push_back(i);
        if (cand.size() == 0 || $urandom_range(0, 3) == 0) return $urandom_range(0, NP + 3);
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        alloc_req_valid = 1'b0; alloc_req_id = '0; alloc_req_count = '0;
        free_req_valid = 1'b0; free_req_id = '0; free_req_page = '0;
        alloc_rsp_ready = 1'b0; free_rsp_ready = 1'b0;

        // Reset and init sweep: NP writes then one cycle to publish
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (NP) @(posedge clk);
        #1 chk("init_done_at_16", init_done, 0);
        chk("ready_before_init", alloc_req_ready | free_req_ready, 0);
        @(posedge clk);
        #1 chk("init_done_at_17", init_done, 1);
        chk("fpc_after_init", free_page_count, 16);

        // Basic 3-page alloc
        glog.delete();
        do_alloc(5, 3); wait_idle();
        chk("a1_nbeats", glog.size(), 3);
        chk_beat("a1_b0", 0, 5, 0, 0, 0, 0);
        chk_beat("a1_b1", 1, 5, 1, 0, 0, 0);
        chk_beat("a1_b2", 2, 5, 2, 1, 0, 0);
        chk("fpc_after_a1", free_page_count, 13);

        // Free, double free, out of range
        flog.delete();
        do_free(1, 1); wait_idle();
        do_free(2, 1); wait_idle();
        do_free(3, 20); wait_idle();
        chk_frsp("free_ok", 0, 1, 0, 0);
        chk_frsp("free_double", 1, 2, 1, 3);
        chk_frsp("free_range", 2, 3, 1, 3);
        chk("fpc_after_frees", free_page_count, 14);

        // Bad sizes
        glog.delete();
        do_alloc(6, 0); wait_idle();
        do_alloc(7, 5); wait_idle();
        chk_beat("bad_size0", 0, 6, 0, 1, 1, 2);
        chk_beat("bad_size5", 1, 7, 0, 1, 1, 2);
        chk("fpc_after_badsize", free_page_count, 14);

        // Drain: list order is 3..15 then 1
        glog.delete();
        for (int i = 0; i < 3; i++) begin do_alloc(20 + i, 4); wait_idle(); end
        do_alloc(30, 4); wait_idle();
        do_alloc(31, 2); wait_idle();
        do_alloc(32, 1); wait_idle();
        chk_beat("drain_first", 0, 20, 3, 0, 0, 0);
        chk_beat("drain_mid", 11, 22, 14, 1, 0, 0);
        chk_beat("nospace4", 12, 30, 0, 1, 1, 1);
        chk_beat("tail_a", 13, 31, 15, 0, 0, 0);
        chk_beat("tail_b", 14, 31, 1, 1, 0, 0);
        chk_beat("nospace1", 15, 32, 0, 1, 1, 1);
        chk("fpc_drained", free_page_count, 0);
        do_free(33, 3); wait_idle();
        glog.delete();
        do_alloc(34, 1); wait_idle();
        chk_beat("wrap_page3", 0, 34, 3, 1, 0, 0);

        // Stall mid-stream with a concurrent free
        do_free(40, 4); wait_idle();
        do_free(41, 5); wait_idle();
        do_free(42, 6); wait_idle();
        amode = 0;
        glog.delete(); flog.delete();
        do_alloc(43, 2);
        fork
            do_free(44, 7);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stall_valid", alloc_rsp_valid, 1);
                chk("stall_page", alloc_rsp_page, 4);
                chk("stall_last", alloc_rsp_last, 0);
            end
        join
        amode = 1;
        wait_idle();
        chk_beat("stall_b0", 0, 43, 4, 0, 0, 0);
        chk_beat("stall_b1", 1, 43, 5, 1, 0, 0);
        chk_frsp("stall_free", 0, 44, 0, 0);
        chk("fpc_after_stall", free_page_count, 2);

        // Reset mid-stream
        amode = 0;
        do_alloc(50, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_fpc", free_page_count, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_valid", alloc_rsp_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        amode = 1;
        repeat (NP + 1) @(posedge clk);
        #1 chk("reinit_done", init_done, 1);
        chk("reinit_fpc", free_page_count, 16);

        // Random traffic against the model
        amode = 2; fmode = 2;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 4);
            if (op == 0)
                do_alloc($urandom_range(0, 255), $urandom_range(0, 5));
            else if (op <= 2)
                do_free($urandom_range(0, 255), pick_page());
            else
                fork
                    do_alloc($urandom_range(0, 255), $urandom_range(1, 4));
                    do_free($urandom_range(0, 255), pick_page());
                join
        end
        amode = 1; fmode = 1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
